// File: rtl/nexys_starship_pkg.sv
// Shared constants for the starship shot controller: directions, one-hot
// state encodings and the spawn LFSR seed/taps.
package nexys_starship_pkg;

    localparam logic [1:0] DIR_TOP    = 2'd0;
    localparam logic [1:0] DIR_BOTTOM = 2'd1;
    localparam logic [1:0] DIR_LEFT   = 2'd2;
    localparam logic [1:0] DIR_RIGHT  = 2'd3;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_READY  = 5'b00010,
        ST_FIRE   = 5'b00100,
        ST_COOL   = 5'b01000,
        ST_RELOAD = 5'b10000
    } shot_state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Right-shifting Galois form of x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        lfsr_step = {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr.sv
// 8-bit Galois LFSR with enable; resets asynchronously to the package seed.
module nexys_starship_lfsr
    import nexys_starship_pkg::*;
(
    input  logic       timer_clk,
    input  logic       Reset,
    input  logic       en_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/nexys_starship_shot_ctrl.sv
// Player shot controller: resolves shots against the monster presence flags,
// drives spawn enables and game over. STARSHIP_RELOAD_EN enables the finite magazine.
module nexys_starship_shot_ctrl
    import nexys_starship_pkg::*;
#(
    parameter int         SHOT_TICKS     = 2,
    parameter int         COOLDOWN_TICKS = 3,
    parameter int         AMMO_MAX       = 5,
    parameter int         RELOAD_TICKS   = 8,
    parameter logic [7:0] RAND_MASK      = 8'h07
) (
    input  logic       timer_clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       shoot_btn,
    input  logic [1:0] shoot_dir,
    input  logic [3:0] monster_sm,
    input  logic [3:0] monster_gameover,
    output logic [3:0] monster_ctrl,
    output logic [3:0] monster_random,
    output logic       gameover_ctrl,
    output logic [2:0] ammo,
    output logic [7:0] hit_count,
    output logic       q_Idle,
    output logic       q_Ready,
    output logic       q_Fire,
    output logic       q_Cool,
    output logic       q_Reload
);

    if (SHOT_TICKS < 1 || SHOT_TICKS > 255 || COOLDOWN_TICKS < 0 || COOLDOWN_TICKS > 255 ||
        AMMO_MAX < 1 || AMMO_MAX > 7 || RELOAD_TICKS < 1 || RELOAD_TICKS > 255) begin : g_param_check
        $error("nexys_starship_shot_ctrl: parameter out of range");
    end

    localparam logic [7:0] SHOT_LAST = 8'(SHOT_TICKS - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_TICKS - 1);
    localparam logic [2:0] AMMO_FULL = 3'(AMMO_MAX);
`ifdef STARSHIP_RELOAD_EN
    localparam logic [7:0] RELOAD_LAST = 8'(RELOAD_TICKS - 1);
`endif

    shot_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  target_q, target_d;
    logic [2:0]  ammo_q, ammo_d;
    logic [7:0]  hit_q, hit_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [3:0]  rand_q, rand_d;
    logic        go_q, go_d;
    logic [3:0]  kill;
    logic        go_event;
    logic        resolve;
    logic [7:0]  lfsr;

    nexys_starship_lfsr u_lfsr (
        .timer_clk (timer_clk),
        .Reset     (Reset),
        .en_i      (1'b1),
        .lfsr_o    (lfsr)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        ammo_d   = ammo_q;
        hit_d    = hit_q;
        go_d     = go_q;
        ctrl_d   = 4'b0000;
        rand_d   = 4'b0000;
        kill     = 4'b0000;
        go_event = (state_q != ST_IDLE) && (|monster_gameover);
        resolve  = (state_q == ST_FIRE) && (cnt_q == SHOT_LAST);

        case (state_q)
            ST_IDLE: begin
                cnt_d    = 8'd0;
                target_d = 2'd0;
                ammo_d   = AMMO_FULL;
                // Dropping play_flag for a tick is the restart handshake.
                if (!play_flag) begin
                    go_d = 1'b0;
                end else if (!go_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (shoot_btn && (ammo_q != 3'd0)) begin
                    target_d = shoot_dir;
                    cnt_d    = 8'd0;
                    state_d  = ST_FIRE;
`ifdef STARSHIP_RELOAD_EN
                    ammo_d   = ammo_q - 3'd1;
`endif
                end
            end
            ST_FIRE: begin
                cnt_d = cnt_q + 8'd1;
                if (resolve) begin
                    cnt_d = 8'd0;
                    if (monster_sm[target_q]) begin
                        kill[target_q] = 1'b1;
                        if (hit_q != 8'hFF) begin
                            hit_d = hit_q + 8'd1;
                        end
                    end
`ifdef STARSHIP_RELOAD_EN
                    if (ammo_q == 3'd0) begin
                        state_d = ST_RELOAD;
                    end else
`endif
                    if (COOLDOWN_TICKS == 0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_COOL;
                    end
                end
            end
            ST_COOL: begin
                if (cnt_q == COOL_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef STARSHIP_RELOAD_EN
            ST_RELOAD: begin
                if (cnt_q == RELOAD_LAST) begin
                    cnt_d   = 8'd0;
                    ammo_d  = AMMO_FULL;
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE) begin
            ctrl_d = monster_sm & ~kill;
            for (int d = 0; d < 4; d++) begin
                rand_d[d] = ((lfsr & RAND_MASK) == 8'(d)) && !monster_sm[d];
            end
        end

        // Game over beats every other transition, including a same-tick kill.
        if (go_event) begin
            go_d     = 1'b1;
            state_d  = ST_IDLE;
            cnt_d    = 8'd0;
            target_d = 2'd0;
            ammo_d   = AMMO_FULL;
            hit_d    = hit_q;
            ctrl_d   = 4'b0000;
            rand_d   = 4'b0000;
        end
    end

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            target_q <= 2'd0;
            ammo_q   <= AMMO_FULL;
            hit_q    <= 8'd0;
            ctrl_q   <= 4'b0000;
            rand_q   <= 4'b0000;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            ammo_q   <= ammo_d;
            hit_q    <= hit_d;
            ctrl_q   <= ctrl_d;
            rand_q   <= rand_d;
            go_q     <= go_d;
        end
    end

    assign monster_ctrl   = ctrl_q;
    assign monster_random = rand_q;
    assign gameover_ctrl  = go_q;
    assign ammo           = ammo_q;
    assign hit_count      = hit_q;
    assign q_Idle         = (state_q == ST_IDLE);
    assign q_Ready        = (state_q == ST_READY);
    assign q_Fire         = (state_q == ST_FIRE);
    assign q_Cool         = (state_q == ST_COOL);
`ifdef STARSHIP_RELOAD_EN
    assign q_Reload       = (state_q == ST_RELOAD);
`else
    assign q_Reload       = 1'b0;
`endif

endmodule

// File: tb/tb_nexys_starship_shot_ctrl.sv
// Self-checking bench for nexys_starship_shot_ctrl; shot results are queued as
// {hit_count, monster_ctrl} when a shot is launched and compared at resolution.
module tb_nexys_starship_shot_ctrl;

    localparam int SHOT_TICKS     = 2;
    localparam int COOLDOWN_TICKS = 3;
    localparam int AMMO_MAX       = 5;
    localparam int RELOAD_TICKS   = 8;

    logic       timer_clk = 1'b0;
    logic       Reset;
    logic       play_flag;
    logic       shoot_btn;
    logic [1:0] shoot_dir;
    logic [3:0] monster_sm;
    logic [3:0] monster_gameover;
    logic [3:0] monster_ctrl;
    logic [3:0] monster_random;
    logic       gameover_ctrl;
    logic [2:0] ammo;
    logic [7:0] hit_count;
    logic       q_Idle, q_Ready, q_Fire, q_Cool, q_Reload;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  hit_model;
    logic [2:0]  ammo_model;

    nexys_starship_shot_ctrl #(
        .SHOT_TICKS     (SHOT_TICKS),
        .COOLDOWN_TICKS (COOLDOWN_TICKS),
        .AMMO_MAX       (AMMO_MAX),
        .RELOAD_TICKS   (RELOAD_TICKS),
        .RAND_MASK      (8'h07)
    ) dut (
        .timer_clk        (timer_clk),
        .Reset            (Reset),
        .play_flag        (play_flag),
        .shoot_btn        (shoot_btn),
        .shoot_dir        (shoot_dir),
        .monster_sm       (monster_sm),
        .monster_gameover (monster_gameover),
        .monster_ctrl     (monster_ctrl),
        .monster_random   (monster_random),
        .gameover_ctrl    (gameover_ctrl),
        .ammo             (ammo),
        .hit_count        (hit_count),
        .q_Idle           (q_Idle),
        .q_Ready          (q_Ready),
        .q_Fire           (q_Fire),
        .q_Cool           (q_Cool),
        .q_Reload         (q_Reload)
    );

    // Clock / watchdog
    always #5 timer_clk = ~timer_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge timer_clk);
        #1;
    endtask

    task automatic sb_check(input string tag);
        logic [11:0] e;
        check_eq({tag, "_queued"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_ctrl"}, monster_ctrl, e[3:0]);
            check_eq({tag, "_hit"}, hit_count, e[11:4]);
        end
    endtask

    // Launch one shot from READY and follow it back to READY.
    task automatic do_shot(input logic [1:0] dir, input bit drop_test);
        logic [3:0] kmask;
        kmask = monster_sm & (4'b0001 << dir);
        if (kmask != 4'b0000 && hit_model != 8'hFF) hit_model++;
        exp_q.push_back({hit_model, monster_sm & ~kmask});
`ifdef STARSHIP_RELOAD_EN
        ammo_model--;
`endif
        shoot_btn = 1'b1;
        shoot_dir = dir;
        tick();
        shoot_btn = 1'b0;
        check_eq("shot_ammo", ammo, ammo_model);
        check_eq("shot_fire", q_Fire, 1);
        for (int i = 0; i < SHOT_TICKS; i++) begin
            check_eq("shot_alive", monster_ctrl, monster_sm);
            tick();
        end
        sb_check("shot");
`ifdef STARSHIP_RELOAD_EN
        if (ammo_model == 3'd0) begin
            check_eq("reload_state", q_Reload, 1);
            shoot_btn = 1'b1;
            tick();
            shoot_btn = 1'b0;
            repeat (RELOAD_TICKS - 2) tick();
            check_eq("reload_hold", q_Reload, 1);
            check_eq("reload_ammo", ammo, 0);
            tick();
            ammo_model = 3'(AMMO_MAX);
            check_eq("reload_ready", q_Ready, 1);
            check_eq("reload_full", ammo, ammo_model);
            return;
        end
`endif
        for (int i = 0; i < COOLDOWN_TICKS; i++) begin
            check_eq("cool_state", q_Cool, 1);
            shoot_btn = drop_test && (i == 0 || i == COOLDOWN_TICKS - 1);
            tick();
        end
        shoot_btn = 1'b0;
        check_eq("cool_ready", q_Ready, 1);
        check_eq("cool_ammo", ammo, ammo_model);
    endtask

    initial begin
        bit seen_rand;
        Reset            = 1'b1;
        play_flag        = 1'b0;
        shoot_btn        = 1'b0;
        shoot_dir        = 2'd0;
        monster_sm       = 4'b0000;
        monster_gameover = 4'b0000;
        hit_model        = 8'd0;
        ammo_model       = 3'(AMMO_MAX);
        repeat (3) tick();

        check_eq("rst_state", {q_Reload, q_Cool, q_Fire, q_Ready, q_Idle}, 5'b00001);
        check_eq("rst_ctrl", monster_ctrl, 0);
        check_eq("rst_rand", monster_random, 0);
        check_eq("rst_go", gameover_ctrl, 0);
        check_eq("rst_ammo", ammo, AMMO_MAX);
        check_eq("rst_hit", hit_count, 0);

        Reset = 1'b0;
        tick();
        check_eq("idle_wait", q_Idle, 1);
        play_flag = 1'b1;
        tick();
        check_eq("to_ready", q_Ready, 1);

        // Basic kill on top
        monster_sm = 4'b0001;
        tick();
        check_eq("ctrl_follow", monster_ctrl, 4'b0001);
        do_shot(2'd0, 1'b0);

        // Miss to the right, with presses dropped during cooldown
        monster_sm = 4'b0010;
        tick();
        do_shot(2'd3, 1'b1);
        do_shot(2'd1, 1'b0);
        do_shot(2'd2, 1'b0);
        do_shot(2'd1, 1'b0);

        // Game over landing on the resolve tick of a would-be kill
        monster_sm = 4'b0001;
        tick();
        exp_q.push_back({hit_model, 4'b0000});
        shoot_btn = 1'b1;
        shoot_dir = 2'd0;
        tick();
        shoot_btn = 1'b0;
        tick();
        monster_gameover = 4'b0100;
        tick();
        monster_gameover = 4'b0000;
        sb_check("gameover");
        check_eq("go_set", gameover_ctrl, 1);
        check_eq("go_idle", q_Idle, 1);
        check_eq("go_rand", monster_random, 0);
        ammo_model = 3'(AMMO_MAX);
        check_eq("go_ammo", ammo, ammo_model);
        repeat (3) tick();
        check_eq("go_hold", gameover_ctrl, 1);
        check_eq("go_hold_idle", q_Idle, 1);
        play_flag = 1'b0;
        tick();
        check_eq("go_clear", gameover_ctrl, 0);
        play_flag = 1'b1;
        tick();
        check_eq("restart_ready", q_Ready, 1);

        // Spawn enables with a fixed occupancy pattern
        monster_sm = 4'b0101;
        seen_rand = 1'b0;
        tick();
        for (int i = 0; i < 300; i++) begin
            tick();
            check_eq("rand_onehot", $countones(monster_random) <= 1, 1);
            check_eq("rand_occupied", monster_random & 4'b0101, 0);
            if (monster_random != 4'b0000) seen_rand = 1'b1;
        end
        check_eq("rand_active", seen_rand, 1);

        // Spawn enables against random occupancy
        for (int i = 0; i < 100; i++) begin
            monster_sm = 4'($urandom_range(0, 15));
            tick();
            check_eq("rnd_ctrl", monster_ctrl, monster_sm);
            check_eq("rnd_rand", monster_random & monster_sm, 0);
            check_eq("rnd_onehot", $countones(monster_random) <= 1, 1);
        end

        // Score saturation
        monster_sm = 4'b0001;
        tick();
        for (int i = 0; i < 258; i++) begin
            do_shot(2'd0, 1'b0);
        end
        check_eq("hit_saturate", hit_count, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nexys_starship_shot_ctrl.md
# nexys_starship_shot_ctrl

Player-side counterpart to the per-direction monster state machines. It samples each monster's presence flag and drives back the matching `monster_ctrl` bit, which stays high while the monster lives and drops when a player shot lands. It also produces the per-direction random spawn enables and the shared game-over request. It sits between the debounced button/switch front end and the four monster SMs (top, bottom, left, right), and runs on the game tick.

## Interface
Parameters:
- `SHOT_TICKS`, default 2: timer_clk ticks from shot launch to hit resolution (≥1).
- `COOLDOWN_TICKS`, default 3: ticks after resolution before the next shot is accepted (≥0).
- `AMMO_MAX`, default 5: magazine size (1..7).
- `RELOAD_TICKS`, default 8: ticks to refill an empty magazine (≥1).
- `RAND_MASK`, default 8'h07: random enable for direction d fires when `(lfsr & RAND_MASK) == d`.

Ports:
- `timer_clk` in 1: game tick clock.
- `Reset` in 1: reset, asynchronous, active-high.
- `play_flag` in 1: start/continue game; level-sensitive.
- `shoot_btn` in 1: single-tick shot request pulse, already debounced.
- `shoot_dir` in 2: 0=top, 1=bottom, 2=left, 3=right; sampled with `shoot_btn`.
- `monster_sm` in 4: monster-present flags, bit index = direction.
- `monster_gameover` in 4: per-direction game-over flags.
- `monster_ctrl` out 4: kept-alive flags back to the monster SMs.
- `monster_random` out 4: spawn enables, at most one bit high per tick.
- `gameover_ctrl` out 1: latched game-over request to all monster SMs.
- `ammo` out 3: rounds remaining.
- `hit_count` out 8: score.
- `q_Idle`, `q_Ready`, `q_Fire`, `q_Cool`, `q_Reload` out 1 each: one-hot state.

## Operation
- **States:** IDLE, READY, FIRE, COOL, RELOAD.
- **Reset values:** state=IDLE, `monster_ctrl`=0, `monster_random`=0, `gameover_ctrl`=0, `ammo`=AMMO_MAX, `hit_count`=0, counters=0, target register=0, LFSR=8'hA5.
- **IDLE:**
  - Outputs are held at their reset values, except that the LFSR keeps running.
  - `play_flag`=1 → READY.
- **READY:**
  - On `shoot_btn`=1 with `ammo`>0: latch `shoot_dir` into the target register, decrement `ammo`, clear the tick counter, then go to FIRE.
  - `shoot_btn` with `ammo`=0 is ignored.
- **FIRE:**
  - The tick counter increments each tick.
  - When counter == SHOT_TICKS−1, resolve the hit:
    - if `monster_sm[target]`=1: a kill pulse clears `monster_ctrl[target]` and `hit_count` increments, saturating at 255;
    - otherwise the shot misses.
  - Then go to COOL, or to RELOAD if `ammo`=0.
- **COOL:** counts COOLDOWN_TICKS ticks, then returns to READY. With COOLDOWN_TICKS=0 it goes straight to READY on the next tick.
- **RELOAD:** counts RELOAD_TICKS ticks, sets `ammo`=AMMO_MAX, then goes to READY.
- **`shoot_btn` outside READY:** dropped. Requests are not queued.
- **`monster_ctrl[d]` (all non-IDLE states):** registered each tick as `monster_sm[d] & ~kill[d]`. A monster appearing during FIRE for the current target is eligible if it is present on the resolve tick.
- **`monster_random`:** one 8-bit Galois LFSR (taps 8,6,5,4) advances every tick. Bit d goes high for one tick when `(lfsr & RAND_MASK) == d` and `monster_sm[d]`=0 and state≠IDLE.
- **`gameover_ctrl`:**
  - Set when any `monster_gameover` bit is 1 while not in IDLE.
  - The same tick, state is forced to IDLE, overriding any transition.
  - While `gameover_ctrl`=1 and `play_flag`=1, the block stays in IDLE.
  - It clears when `play_flag`=0 for one tick, which is the restart handshake.
- **Reset mid-shot:** aborts with no kill and no score change.

## Timing
- Every output is registered on `timer_clk`. Nothing is combinational from inputs to outputs.
- Shot latency: `shoot_btn` tick T → `monster_ctrl[target]` low at T+1+SHOT_TICKS.
- `ammo` decrements at T+1. `hit_count` increments in the same tick as the `monster_ctrl` drop.
- READY re-entry after a shot:
  - normal: T+1+SHOT_TICKS+COOLDOWN_TICKS;
  - empty magazine: T+1+SHOT_TICKS+RELOAD_TICKS.
- Game over and a kill in the same tick: game over wins; the kill is discarded and the score is unchanged.
- Counters are 8 bits wide and compared for equality. Parameter values above 255 are illegal.

## Configuration
- `STARSHIP_RELOAD_EN` defined: finite magazine and RELOAD state, as described above.
- Not defined:
  - `ammo` is constant AMMO_MAX and never decrements;
  - the RELOAD state and its counter are not built, and `q_Reload` is tied to 0;
  - FIRE always proceeds to COOL.

## Structure
- **Package `nexys_starship_pkg`:**
  - direction constants DIR_TOP=0, DIR_BOTTOM=1, DIR_LEFT=2, DIR_RIGHT=3;
  - one-hot state encodings for this block;
  - LFSR seed and tap constant.
- **Sub-module `nexys_starship_lfsr`:** 8-bit Galois LFSR with enable and async reset to the seed, reusable by other spawn logic.

## Test plan
- **Basic kill:** Reset, `play_flag`=1, `monster_sm`=4'b0001, shot with dir=0 at T → `monster_ctrl`=4'b0001 until T+3, then 0; `hit_count`=1; `ammo`=4.
- **Miss:** `monster_sm`=4'b0010, shot with dir=3 → `monster_ctrl[1]` stays 1; `hit_count` is unchanged; `ammo` decrements.
- **Cooldown drop:** second `shoot_btn` at T+3 and again at T+5 → both ignored; a press at T+6 is accepted.
- **Magazine empty (`STARSHIP_RELOAD_EN` defined):**
  - after 5 shots, `ammo`=0 and `q_Reload`=1;
  - a press during reload has no effect;
  - after 8 ticks, `ammo`=5 and `q_Ready`=1.
- **Game over mid-shot:** `monster_gameover`=4'b0100 during FIRE → next tick `gameover_ctrl`=1, `q_Idle`=1, `monster_ctrl`=0, no score change. Then `play_flag`=0 for one tick and back to 1 → `gameover_ctrl`=0, READY.
- **Random exclusivity:** 300 ticks in READY with `monster_sm`=4'b0101 → `monster_random` is never multi-hot and bits 0 and 2 stay 0.
